// File: rtl/pwl_pkg.sv
// Shared types and defaults for the piecewise-linear activation unit.
// Default tables are chords of the sigmoid over 0.5-wide segments in Q8.8.
package pwl_pkg;

    typedef enum logic [1:0] {
        MODE_SIGMOID = 2'd0,
        MODE_TANH    = 2'd1,
        MODE_RELU    = 2'd2,
        MODE_IDENT   = 2'd3
    } mode_e;

    localparam int DATA_W_DEF    = 16;
    localparam int FRAC_W_DEF    = 8;
    localparam int SEG_N_DEF     = 13;
    localparam int SEG_SHIFT_DEF = 7;

    // Segment k spans xa in [128k, 128k+127]; y = (xa*slope >> 8) + intercept
    localparam logic [15:0] SLOPE_DEF [SEG_N_DEF] = '{
        16'd62, 16'd56, 16'd44, 16'd32, 16'd24, 16'd14, 16'd8,
        16'd6,  16'd4,  16'd2,  16'd2,  16'd0,  16'd0
    };

    localparam logic [15:0] ICPT_DEF [SEG_N_DEF] = '{
        16'h0080, 16'd131, 16'd143, 16'd161, 16'd177, 16'd202, 16'd220,
        16'd227,  16'd235, 16'd244, 16'd244, 16'd255, 16'h0100
    };

endpackage

// File: rtl/pwl_activation_if.sv
// Valid/ready stream interface: sample in, activation result out.
interface pwl_activation_if
    import pwl_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [1:0]        in_mode;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;

    modport master (
        output in_valid, in_data, in_mode, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, in_mode, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/pwl_coef_table.sv
// Slope/intercept tables with one write port and a combinational read port.
// PWL_COEF_WR_EN makes the tables writable; otherwise they are a constant ROM.
module pwl_coef_table
    import pwl_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int SEG_N  = SEG_N_DEF
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic              sel,
    input  logic [3:0]        waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [3:0]        raddr,
    output logic [DATA_W-1:0] slope,
    output logic [DATA_W-1:0] icpt
);

`ifdef PWL_COEF_WR_EN
    logic [DATA_W-1:0] slope_q [SEG_N];
    logic [DATA_W-1:0] icpt_q  [SEG_N];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SEG_N; i++) begin
                slope_q[i] <= DATA_W'(SLOPE_DEF[i]);
                icpt_q[i]  <= DATA_W'(ICPT_DEF[i]);
            end
        end else if (we && (waddr < 4'(SEG_N))) begin
            if (sel)
                icpt_q[waddr]  <= wdata;
            else
                slope_q[waddr] <= wdata;
        end
    end

    assign slope = slope_q[raddr];
    assign icpt  = icpt_q[raddr];
`else
    wire unused_ok = ^{clk, rst_n, we, sel, waddr, wdata};

    assign slope = DATA_W'(SLOPE_DEF[raddr]);
    assign icpt  = DATA_W'(ICPT_DEF[raddr]);
`endif

endmodule

// File: rtl/pwl_activation.sv
// Three-stage piecewise-linear activation (sigmoid/tanh/ReLU/identity) with global stall.
// Coefficient writes are live only when built with PWL_COEF_WR_EN.
module pwl_activation
    import pwl_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int FRAC_W    = FRAC_W_DEF,
    parameter int SEG_N     = SEG_N_DEF,
    parameter int SEG_SHIFT = SEG_SHIFT_DEF
)(
    input  logic              clk,
    input  logic              rst_n,
    pwl_activation_if.slave   io,
    input  logic              coef_we,
    input  logic              coef_sel,
    input  logic [3:0]        coef_addr,
    input  logic [DATA_W-1:0] coef_data
);

    localparam int W2 = DATA_W + 2;
    localparam logic signed [W2-1:0] ONE_W   = W2'(1 << FRAC_W);
    localparam logic signed [W2-1:0] POS_MAX = {3'b000, {(DATA_W-1){1'b1}}};
    localparam logic signed [W2-1:0] NEG_MIN = {3'b111, {(DATA_W-1){1'b0}}};

    logic en;
    assign en          = !io.out_valid || io.out_ready;
    assign io.in_ready = en;

    // ---------------- stage 1: pre-scale, fold to |x|, segment index
    logic signed [W2-1:0] x_w, xp_w;
    logic [DATA_W-1:0]    xp, xa, seg_idx;
    logic                 neg;
    logic [3:0]           addr;

    always_comb begin
        x_w  = {{2{io.in_data[DATA_W-1]}}, io.in_data};
        xp_w = (io.in_mode == MODE_TANH) ? (x_w <<< 1) : x_w;
        if (xp_w > POS_MAX)
            xp = POS_MAX[DATA_W-1:0];
        else if (xp_w < NEG_MIN)
            xp = NEG_MIN[DATA_W-1:0];
        else
            xp = xp_w[DATA_W-1:0];
        neg = xp[DATA_W-1];
        if (!neg)
            xa = xp;
        else if (xp == NEG_MIN[DATA_W-1:0])
            xa = POS_MAX[DATA_W-1:0];
        else
            xa = -xp;
        seg_idx = xa >> SEG_SHIFT;
        addr    = (seg_idx > DATA_W'(SEG_N - 1)) ? 4'(SEG_N - 1) : seg_idx[3:0];
    end

    logic              s1_valid, s1_neg;
    logic [DATA_W-1:0] s1_xa, s1_x;
    logic [3:0]        s1_addr;
    mode_e             s1_mode;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_neg   <= 1'b0;
            s1_xa    <= '0;
            s1_x     <= '0;
            s1_addr  <= '0;
            s1_mode  <= MODE_SIGMOID;
        end else if (en) begin
            s1_valid <= io.in_valid;
            s1_neg   <= neg;
            s1_xa    <= xa;
            s1_x     <= io.in_data;
            s1_addr  <= addr;
            s1_mode  <= mode_e'(io.in_mode);
        end
    end

    // ---------------- stage 2: table lookup and slope product
    logic [DATA_W-1:0]   slope, icpt, mx;
    logic [2*DATA_W-1:0] prod, prod_sh;

    pwl_coef_table #(
        .DATA_W (DATA_W),
        .SEG_N  (SEG_N)
    ) u_coef (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (coef_we),
        .sel   (coef_sel),
        .waddr (coef_addr),
        .wdata (coef_data),
        .raddr (s1_addr),
        .slope (slope),
        .icpt  (icpt)
    );

    // Written slopes can be large; clamp rather than wrap the product
    always_comb begin
        prod    = (2*DATA_W)'(s1_xa) * (2*DATA_W)'(slope);
        prod_sh = prod >> FRAC_W;
        mx      = (prod_sh > (2*DATA_W)'({DATA_W{1'b1}})) ? '1 : prod_sh[DATA_W-1:0];
    end

    logic              s2_valid, s2_neg;
    logic [DATA_W-1:0] s2_mx, s2_icpt, s2_x;
    mode_e             s2_mode;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_neg   <= 1'b0;
            s2_mx    <= '0;
            s2_icpt  <= '0;
            s2_x     <= '0;
            s2_mode  <= MODE_SIGMOID;
        end else if (en) begin
            s2_valid <= s1_valid;
            s2_neg   <= s1_neg;
            s2_mx    <= mx;
            s2_icpt  <= icpt;
            s2_x     <= s1_x;
            s2_mode  <= s1_mode;
        end
    end

    // ---------------- stage 3: add intercept, mirror, apply mode
    logic signed [W2-1:0] sum, y, s;
    logic [DATA_W-1:0]    z;

    always_comb begin
        sum = {2'b00, s2_mx} + {{2{s2_icpt[DATA_W-1]}}, s2_icpt};
        // The sigmoid half-curve is kept inside [0, ONE] so the mirror stays in range
        if (sum[W2-1])
            y = '0;
        else if (sum > ONE_W)
            y = ONE_W;
        else
            y = sum;
        s = s2_neg ? (ONE_W - y) : y;
        z = '0;
        unique case (s2_mode)
            MODE_SIGMOID: z = DATA_W'(s);
            MODE_TANH:    z = DATA_W'((s <<< 1) - ONE_W);
            MODE_RELU:    z = s2_x[DATA_W-1] ? '0 : s2_x;
            default:      z = s2_x;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            io.out_valid <= 1'b0;
            io.out_data  <= '0;
        end else if (en) begin
            io.out_valid <= s2_valid;
            if (s2_valid)
                io.out_data <= z;
        end
    end

endmodule

// File: doc/pwl_activation.md
PWL_ACTIVATION -- requirements
Module: pwl_activation

Interface
REQ-001 SHALL have parameters, one per line:
- DATA_W, 16, signed fixed-point sample width.
- FRAC_W, 8, fractional bits; ONE = 1<<FRAC_W.
- SEG_N, 13, number of linear segments.
- SEG_SHIFT, 7, log2 of segment width in LSBs.
REQ-002 SHALL have ports, one per line:
- clk, in, 1, single clock.
- rst_n, in, 1, asynchronous active-low reset.
- in_valid, in, 1, input sample valid.
- in_ready, out, 1, block accepts input.
- in_data, in, DATA_W, signed input x.
- in_mode, in, 2, 0=sigmoid, 1=tanh, 2=ReLU, 3=identity.
- out_valid, out, 1, result valid.
- out_ready, in, 1, downstream accepts result.
- out_data, out, DATA_W, signed result z.
- coef_we, in, 1, coefficient write strobe.
- coef_sel, in, 1, 0=slope table, 1=intercept table.
- coef_addr, in, 4, segment index.
- coef_data, in, DATA_W, coefficient value.
REQ-003 SHALL use one clock, clk; reset rst_n is asynchronous, active-low.

Function
REQ-004 SHALL transfer input when in_valid&&in_ready and output when out_valid&&out_ready.
REQ-005 SHALL be a 3-stage pipeline with latency exactly 3 cycles from input transfer to out_valid when unstalled, throughput 1/cycle.
REQ-006 SHALL stall globally: in_ready = !out_valid || out_ready; when stalled all stages hold; no sample dropped or duplicated, order preserved.
REQ-007 Stage 1 SHALL: for tanh, x' = sat(2x), else x' = x; neg = x'[MSB]; xa = |x'|, with most-negative value mapped to max positive; addr = min(xa>>SEG_SHIFT, SEG_N-1).
REQ-008 Stage 2 SHALL read slope[addr], intercept[addr] and compute mx = (xa*slope)>>FRAC_W (unsigned, truncate toward zero).
REQ-009 Stage 3 SHALL compute y = min(mx+intercept, ONE); s = neg ? ONE-y : y.
REQ-010 Output SHALL be: sigmoid s; tanh 2s-ONE; ReLU max(x,0); identity x; mode carried with its sample through the pipeline.
REQ-011 All intermediate sums SHALL be computed at DATA_W+2 bits and saturated, never wrapped.
REQ-012 Addr SHALL clamp at SEG_N-1 for all xa beyond the last segment boundary.

Reset
REQ-013 On rst_n low: out_valid=0, out_data=0, all stage valids 0, in_ready=1 after release; tables load package defaults.
REQ-014 Reset asserted mid-operation SHALL discard all in-flight samples; no output after release until a new input transfers.

Configuration
REQ-015 With PWL_COEF_WR_EN defined: coef_we writes coef_data to the selected table entry at the clock edge; the new value applies to samples entering stage 2 on the next cycle; addresses >= SEG_N are ignored.
REQ-016 Without PWL_COEF_WR_EN: coef_* ports exist but are ignored; tables are constant package defaults (synthesised as ROM).

Structure
REQ-017 Shared package pwl_pkg SHALL hold mode enum, default DATA_W/FRAC_W/SEG_N, and default sigmoid slope/intercept arrays (intercept[0]=0x0080, slope[SEG_N-1]=0, intercept[SEG_N-1]=0x0100).
REQ-018 One sub-module, pwl_coef_table (two SEG_N x DATA_W tables, one write port, one combinational read port), SHALL hold coefficients.

Verification
REQ-019 Sigmoid: in_data=0x0000 -> out_data=0x0080 exactly 3 cycles later.
REQ-020 Saturation: sigmoid 0x7FFF -> 0x0100; 0x8000 -> 0x0000; tanh 0x7FFF -> 0x0100; tanh 0x0000 -> 0x0000.
REQ-021 ReLU 0xFF00 -> 0x0000, ReLU 0x0280 -> 0x0280; identity 0xFF00 -> 0xFF00.
REQ-022 Back-pressure: stream 8 samples, hold out_ready=0 for 5 cycles mid-stream -> in_ready drops, all 8 outputs appear in order, none lost.
REQ-023 Reset mid-stream with 3 in flight -> out_valid=0 immediately; no stale output after release.
REQ-024 With PWL_COEF_WR_EN: write intercept[0]=0x0040, then sigmoid 0x0000 -> 0x0040; without the macro -> 0x0080.
